// File: rtl/egress.sv
// egress: crossbar output-port receiver. Parses 8-word segment blocks, reassembles kept
// packets into a word FIFO for the host and keeps packet/latency statistics.
// Build option EGRESS_HDR_STRIP_EN: words 0-2 (header, dmac, timestamp) are not forwarded.
module egress #(
  parameter int FIFO_DEPTH  = 64,
  parameter int BLOCK_WORDS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] time_in,
  input  logic [31:0] packet_in,
  input  logic        packet_in_en,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_first,
  output logic        out_last,
  input  logic        out_ready,
  input  logic [1:0]  stat_addr,
  output logic [31:0] stat_data,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  if (FIFO_DEPTH < 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("egress: FIFO_DEPTH must be a power of two, at least 16");
  end
  if (BLOCK_WORDS != 8) begin : g_block_chk
    $error("egress: BLOCK_WORDS must be 8");
  end

  typedef enum logic [1:0] {RX_IDLE, RX_DMAC, RX_TIME, RX_PAYLOAD} rx_state_e;

  rx_state_e     state_q, state_d;
  logic [5:0]    blk_rem_q, blk_rem_d;
  logic [2:0]    wcnt_q, wcnt_d;
  logic          drop_q, drop_d;
  logic [5:0]    hdr_len;
  logic [9:0]    need;
  logic [CW-1:0] occ, free_words;
  logic          no_room;
  logic          end_of_pkt, push, push_first, push_last;
  logic [31:0]   lat;

  logic [33:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] mem_cnt_q, mem_cnt_d;
  logic [33:0]   head_q, head_d, push_word;
  logic          out_valid_q, out_valid_d;
  logic          pop, mem_rd, mem_we;

  logic [31:0]   pkt_count_q, pkt_count_d, drop_count_q, drop_count_d;
  logic [31:0]   last_lat_q, last_lat_d, max_lat_q, max_lat_d, stat_q, stat_d;

  assign hdr_len = packet_in[26:21];
`ifdef EGRESS_HDR_STRIP_EN
  assign need = 10'({hdr_len, 3'b000}) + 10'd8 - 10'd3;
`else
  assign need = 10'({hdr_len, 3'b000}) + 10'd8;
`endif
  // Occupancy includes the registered head word.
  assign occ        = mem_cnt_q + CW'(out_valid_q);
  assign free_words = CW'(FIFO_DEPTH) - occ;
  assign no_room    = 32'(need) > 32'(free_words);
  assign lat        = time_in - packet_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RX_IDLE;
    else          state_q <= state_d;
  end

  // wcnt is the index of the next word within its block; it wraps mod 8.
  always_comb begin
    state_d   = state_q;
    blk_rem_d = blk_rem_q;
    wcnt_d    = wcnt_q;
    drop_d    = drop_q;
    if (packet_in_en) begin
      wcnt_d = wcnt_q + 3'd1;
      case (state_q)
        RX_IDLE: begin
          blk_rem_d = hdr_len;
          wcnt_d    = 3'd1;
          drop_d    = no_room;
          state_d   = RX_DMAC;
        end
        RX_DMAC: state_d = RX_TIME;
        RX_TIME: state_d = RX_PAYLOAD;
        default: begin
          if (wcnt_q == 3'd7) begin
            if (blk_rem_q == 6'd0) state_d = RX_IDLE;
            else                   blk_rem_d = blk_rem_q - 6'd1;
          end
        end
      endcase
    end
  end

`ifdef EGRESS_HDR_STRIP_EN
  logic pl_first_q, pl_first_d;

  always_comb begin
    pl_first_d = pl_first_q;
    if (packet_in_en && state_q == RX_TIME)    pl_first_d = 1'b1;
    if (packet_in_en && state_q == RX_PAYLOAD) pl_first_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pl_first_q <= 1'b0;
    else          pl_first_q <= pl_first_d;
  end
`endif

  always_comb begin
    busy       = (state_q != RX_IDLE);
    push_last  = (state_q == RX_PAYLOAD) && (wcnt_q == 3'd7) && (blk_rem_q == 6'd0);
    end_of_pkt = packet_in_en && push_last;
`ifdef EGRESS_HDR_STRIP_EN
    push       = packet_in_en && (state_q == RX_PAYLOAD) && !drop_q;
    push_first = pl_first_q;
`else
    push       = packet_in_en && ((state_q == RX_IDLE) ? !no_room : !drop_q);
    push_first = (state_q == RX_IDLE);
`endif
  end

  // Host side: a word transfers on a cycle where out_valid and out_ready are both high;
  // out_* hold their value while out_valid=1 and out_ready=0.
  assign push_word = {push_last, push_first, packet_in};

  always_comb begin
    pop         = out_valid_q & out_ready;
    head_d      = head_q;
    out_valid_d = out_valid_q;
    mem_rd      = 1'b0;
    mem_we      = push;
    if (!out_valid_q || pop) begin
      if (mem_cnt_q != '0) begin
        head_d      = mem_q[rd_ptr_q];
        out_valid_d = 1'b1;
        mem_rd      = 1'b1;
      end else if (push) begin
        head_d      = push_word;
        out_valid_d = 1'b1;
        mem_we      = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    rd_ptr_d  = rd_ptr_q + AW'(mem_rd);
    wr_ptr_d  = wr_ptr_q + AW'(mem_we);
    mem_cnt_d = mem_cnt_q + CW'(mem_we) - CW'(mem_rd);
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= push_word;
  end

  always_comb begin
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    last_lat_d   = last_lat_q;
    max_lat_d    = max_lat_q;
    if (packet_in_en && state_q == RX_TIME && !drop_q) begin
      last_lat_d = lat;
      if (lat > max_lat_q) max_lat_d = lat;
    end
    if (end_of_pkt) begin
      if (drop_q) begin
        if (drop_count_q != '1) drop_count_d = drop_count_q + 32'd1;
      end else begin
        if (pkt_count_q != '1) pkt_count_d = pkt_count_q + 32'd1;
      end
    end
    case (stat_addr)
      2'd0:    stat_d = pkt_count_q;
      2'd1:    stat_d = drop_count_q;
      2'd2:    stat_d = last_lat_q;
      default: stat_d = max_lat_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_rem_q    <= '0;
      wcnt_q       <= '0;
      drop_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_cnt_q    <= '0;
      head_q       <= '0;
      out_valid_q  <= 1'b0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
      last_lat_q   <= '0;
      max_lat_q    <= '0;
      stat_q       <= '0;
    end else begin
      blk_rem_q    <= blk_rem_d;
      wcnt_q       <= wcnt_d;
      drop_q       <= drop_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_cnt_q    <= mem_cnt_d;
      head_q       <= head_d;
      out_valid_q  <= out_valid_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
      last_lat_q   <= last_lat_d;
      max_lat_q    <= max_lat_d;
      stat_q       <= stat_d;
    end
  end

  assign out_data  = head_q[31:0];
  assign out_first = out_valid_q & head_q[32];
  assign out_last  = out_valid_q & head_q[33];
  assign out_valid = out_valid_q;
  assign stat_data = stat_q;
endmodule
